v_alu_pipe: RTL and testbench
=============================

V_ALU_PIPE -- requirements
Module: v_alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning lane datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter LATENCY, default 3, meaning the number of cycles from acceptance to result; legal range is 2..6.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port vld_i, input, 1 bit: input beat valid.
REQ-006 SHALL have port rdy_o, output, 1 bit: block can accept a beat.
REQ-007 SHALL have port op_i, input, 4 bits: opcode (alu_op_t).
REQ-008 SHALL have port sew_i, input, 2 bits: element width; 00 is 8-bit, 01 is 16-bit, 10 is 32-bit, 11 is reserved and treated as 10.
REQ-009 SHALL have ports op1_i and op2_i, input, DATA_W bits each: packed source operands.
REQ-010 SHALL have ports red_i, red_first_i and red_last_i, input, 1 bit each: reduction beat, first reduction beat, last reduction beat.
REQ-011 SHALL have port vld_o, output, 1 bit: result valid.
REQ-012 SHALL have port rdy_i, input, 1 bit: downstream ready.
REQ-013 SHALL have port result_o, output, DATA_W bits: packed result.

Function
REQ-014 SHALL accept a beat when vld_i && rdy_o; stall = vld_o && !rdy_i; rdy_o = !stall; all stages and the accumulator SHALL hold while stall is high.
REQ-015 SHALL assert vld_o exactly LATENCY cycles after acceptance of a non-reduction beat, or of a reduction beat with red_last_i, when no stall occurs; stalls SHALL extend the latency 1:1.
REQ-016 SHALL hold result_o stable while vld_o && !rdy_i.
REQ-017 SHALL operate elementwise on DATA_W/8, DATA_W/16 or DATA_W/32 independent elements per sew, with no carry or borrow crossing element boundaries.
REQ-018 Opcodes SHALL be: ADD; SUB (op1-op2); AND; OR; XOR; MIN and MAX (signed); MINU and MAXU; SLT, SLTU and SEQ; MUL (low SEW bits); MULH (signed high SEW bits); MULHU. Remaining codes SHALL produce zero.
REQ-019 Compare ops SHALL place 1/0 in each element's bit 0 and zero in the element's other bits.
REQ-020 SHALL sign-extend per element for signed ops and zero-extend for unsigned ops; multiplies SHALL form the full 2*SEW product before selecting the half.
REQ-021 Reduction beats (red_i=1) SHALL produce no vld_o unless red_last_i=1.
REQ-022 Accumulator acc SHALL load OP(op1, op2) elementwise on red_first_i, and load OP(acc, op2) on the other reduction beats.
REQ-023 Reducible ops SHALL be ADD, AND, OR, XOR, MIN, MAX, MINU and MAXU; any other opcode with red_i SHALL reduce as ADD.
REQ-024 On a beat with red_last_i, result_o SHALL equal the updated acc; red_first_i and red_last_i on the same beat SHALL yield OP(op1, op2).
REQ-025 A reduction beat without red_first_i and with no prior first beat SHALL combine with acc = 0.
REQ-026 Non-reduction beats SHALL be legal between reduction beats and SHALL NOT modify acc.
REQ-027 The acc update SHALL occur at the final stage when the beat advances out of it.

Reset
REQ-028 rstn low SHALL clear all stage valids, acc, vld_o and result_o to 0 on the next edge; rdy_o SHALL be 1 after reset.
REQ-029 Reset mid-reduction or during a stall SHALL discard all in-flight beats; no vld_o SHALL follow.

Structure
REQ-030 Package v_alu_pkg SHALL hold alu_op_t, sew encodings, and the reducible-op predicate function.
REQ-031 SHALL instantiate sub-module v_alu_simd_unit (parametrised by DATA_W, pure combinational elementwise compute) twice: once for the op path and once for the acc combine path.
REQ-032 Pipeline depth SHALL be built with a generate loop; no vendor primitives.

Verification
REQ-033 Verification SHALL cover: DATA_W=32, sew=00, ADD op1=0x7F01FF80, op2=0x01010101 -> result 0x80020081 after 3 cycles, with no inter-byte carry.
REQ-034 Verification SHALL cover: sew=01, MULH op1=0x8000_0002, op2=0x8000_0003 -> 0x4000_0000; MULHU on the same operands -> 0x4000_0000.
REQ-035 Verification SHALL cover: sew=10, SLT op1=0xFFFFFFFF, op2=0 -> 0x00000001; SLTU on the same operands -> 0x00000000.
REQ-036 Verification SHALL cover: reduction MAX, sew=10, beats op1=5/op2=3 (first), op2=9, op2=-2 (last) -> a single vld_o with result 9, and no vld_o on the earlier beats.
REQ-037 Verification SHALL cover: back-to-back ADD beats with rdy_i low for 4 cycles -> rdy_o low, result_o held, no beat lost or duplicated, and in-order delivery.
REQ-038 Verification SHALL cover: rstn pulsed mid-reduction -> vld_o stays 0; a new reduction starting with red_first_i returns the correct fresh value.

Source files
------------

// File: rtl/v_alu_pkg.sv
// Shared types for the vector ALU pipeline: opcodes, element widths and
// the predicate that decides which opcodes are allowed to reduce.
package v_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_MIN   = 4'd5,
    OP_MAX   = 4'd6,
    OP_MINU  = 4'd7,
    OP_MAXU  = 4'd8,
    OP_SLT   = 4'd9,
    OP_SLTU  = 4'd10,
    OP_SEQ   = 4'd11,
    OP_MUL   = 4'd12,
    OP_MULH  = 4'd13,
    OP_MULHU = 4'd14,
    OP_RSVD  = 4'd15
  } alu_op_t;

  // Element width; the reserved code behaves exactly like 32-bit elements.
  typedef enum logic [1:0] {
    SEW_8    = 2'b00,
    SEW_16   = 2'b01,
    SEW_32   = 2'b10,
    SEW_RSVD = 2'b11
  } sew_t;

  // Ops whose partial results can be folded into the accumulator.
  function automatic logic is_reducible(input alu_op_t op);
    return op inside {OP_ADD, OP_AND, OP_OR, OP_XOR,
                      OP_MIN, OP_MAX, OP_MINU, OP_MAXU};
  endfunction

endpackage

// File: rtl/v_alu_simd_unit.sv
// Purely combinational SIMD ALU. Every element width is computed in
// parallel and the requested one is selected at the end, so carries and
// borrows never leave their own element.
module v_alu_simd_unit
  import v_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           op,
  input  sew_t              sew,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] y_sew [3];

  for (genvar g = 0; g < 3; g++) begin : g_sew
    localparam int EW = 8 << g;
    localparam int NE = DATA_W / EW;

    for (genvar e = 0; e < NE; e++) begin : g_el
      logic [EW-1:0]   ea;
      logic [EW-1:0]   eb;
      logic [EW-1:0]   r;
      logic            xa;
      logic            xb;
      logic [2*EW-1:0] prod;

      assign ea = a[e*EW +: EW];
      assign eb = b[e*EW +: EW];

      // One multiplier per element: sign-extend unless the op is MULHU.
      // The low half is the same either way, so MUL shares it.
      assign xa   = (op != OP_MULHU) && ea[EW-1];
      assign xb   = (op != OP_MULHU) && eb[EW-1];
      assign prod = {{EW{xa}}, ea} * {{EW{xb}}, eb};

      // Per-element operation select.
      always_comb begin
        r = '0;
        case (op)
          OP_ADD:   r = ea + eb;
          OP_SUB:   r = ea - eb;
          OP_AND:   r = ea & eb;
          OP_OR:    r = ea | eb;
          OP_XOR:   r = ea ^ eb;
          OP_MIN:   r = ($signed(ea) < $signed(eb)) ? ea : eb;
          OP_MAX:   r = ($signed(ea) < $signed(eb)) ? eb : ea;
          OP_MINU:  r = (ea < eb) ? ea : eb;
          OP_MAXU:  r = (ea < eb) ? eb : ea;
          OP_SLT:   r = {{(EW-1){1'b0}}, ($signed(ea) < $signed(eb))};
          OP_SLTU:  r = {{(EW-1){1'b0}}, (ea < eb)};
          OP_SEQ:   r = {{(EW-1){1'b0}}, (ea == eb)};
          OP_MUL:   r = prod[EW-1:0];
          OP_MULH:  r = prod[2*EW-1:EW];
          OP_MULHU: r = prod[2*EW-1:EW];
          default:  r = '0;
        endcase
      end

      assign y_sew[g][e*EW +: EW] = r;
    end
  end

  // Pick the lane layout that matches the element width.
  always_comb begin
    y = y_sew[2];
    case (sew)
      SEW_8:   y = y_sew[0];
      SEW_16:  y = y_sew[1];
      default: y = y_sew[2];
    endcase
  end

endmodule

// File: rtl/v_alu_pipe.sv
// Pipelined SIMD ALU with reduction support. Operands are computed on
// entry, then travel through LATENCY register stages. Reductions fold into
// the accumulator at the last stage, so beats combine strictly in order
// regardless of pipeline depth.
module v_alu_pipe
  import v_alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic [3:0]        op_i,
  input  logic [1:0]        sew_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic              red_i,
  input  logic              red_first_i,
  input  logic              red_last_i,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic [DATA_W-1:0] result_o
);

  typedef struct packed {
    logic              vld;
    logic              red;
    logic              first;
    logic              last;
    alu_op_t           op;
    sew_t              sew;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] res;
  } stage_t;

  stage_t            stg_q [LATENCY];
  stage_t            beat_in;
  stage_t            tail;
  alu_op_t           eff_op;
  logic [DATA_W-1:0] op_res;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_comb;
  logic [DATA_W-1:0] acc_next;
  logic              stall;

  // Non-reducible opcodes on a reduction beat fall back to ADD.
  assign eff_op = (red_i && !is_reducible(alu_op_t'(op_i))) ? OP_ADD : alu_op_t'(op_i);

  v_alu_simd_unit #(.DATA_W(DATA_W)) u_op_path (
    .op  (eff_op),
    .sew (sew_t'(sew_i)),
    .a   (op1_i),
    .b   (op2_i),
    .y   (op_res)
  );

  // Bundle the incoming beat; op2 is kept for later accumulator combines.
  always_comb begin
    beat_in       = '0;
    beat_in.vld   = vld_i;
    beat_in.red   = red_i;
    beat_in.first = red_i && red_first_i;
    beat_in.last  = red_i && red_last_i;
    beat_in.op    = eff_op;
    beat_in.sew   = sew_t'(sew_i);
    beat_in.op2   = op2_i;
    beat_in.res   = op_res;
  end

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      // First stage captures the accepted beat; holds during a stall.
      always_ff @(posedge clk) begin
        if (!rstn)       stg_q[0] <= '0;
        else if (!stall) stg_q[0] <= beat_in;
      end
    end else begin : g_body
      // Later stages shift forward together; hold during a stall.
      always_ff @(posedge clk) begin
        if (!rstn)       stg_q[g] <= '0;
        else if (!stall) stg_q[g] <= stg_q[g-1];
      end
    end
  end

  assign tail = stg_q[LATENCY-1];

  v_alu_simd_unit #(.DATA_W(DATA_W)) u_acc_path (
    .op  (tail.op),
    .sew (tail.sew),
    .a   (acc_q),
    .b   (tail.op2),
    .y   (acc_comb)
  );

  assign acc_next = tail.first ? tail.res : acc_comb;
  assign vld_o    = tail.vld && (!tail.red || tail.last);
  assign result_o = tail.red ? acc_next : tail.res;
  assign stall    = vld_o && !rdy_i;
  assign rdy_o    = !stall;

  // Accumulator advances only when a reduction beat leaves the last stage.
  always_ff @(posedge clk) begin
    if (!rstn)                                 acc_q <= '0;
    else if (tail.vld && tail.red && !stall)   acc_q <= acc_next;
  end

endmodule

// File: tb/tb_v_alu_pipe.sv
// Bench for v_alu_pipe: directed vectors plus a randomized run checked
// against an element-by-element arithmetic reference model.
module tb_v_alu_pipe;
  import v_alu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int LATENCY = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              vld_i = 1'b0;
  logic              rdy_o;
  logic [3:0]        op_i = '0;
  logic [1:0]        sew_i = '0;
  logic [DATA_W-1:0] op1_i = '0;
  logic [DATA_W-1:0] op2_i = '0;
  logic              red_i = 1'b0;
  logic              red_first_i = 1'b0;
  logic              red_last_i = 1'b0;
  logic              vld_o;
  logic              rdy_i = 1'b1;
  logic [DATA_W-1:0] result_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_acc = '0;

  always #5 clk = ~clk;

  v_alu_pipe #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .vld_i       (vld_i),
    .rdy_o       (rdy_o),
    .op_i        (op_i),
    .sew_i       (sew_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .red_i       (red_i),
    .red_first_i (red_first_i),
    .red_last_i  (red_last_i),
    .vld_o       (vld_o),
    .rdy_i       (rdy_i),
    .result_o    (result_o)
  );

  // Reference: split into elements, do plain integer arithmetic per element.
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [1:0] sew,
                                         input logic [31:0] a, input logic [31:0] b);
    int w, n;
    longint mask, ua, ub, sa, sb, x;
    longint unsigned pu;
    logic [31:0] r;
    w = (sew == 2'b00) ? 8 : (sew == 2'b01) ? 16 : 32;
    n = 32 / w;
    mask = (longint'(1) << w) - 1;
    r = '0;
    for (int i = 0; i < n; i++) begin
      ua = longint'(a >> (i*w)) & mask;
      ub = longint'(b >> (i*w)) & mask;
      sa = (ua >= (longint'(1) << (w-1))) ? ua - (longint'(1) << w) : ua;
      sb = (ub >= (longint'(1) << (w-1))) ? ub - (longint'(1) << w) : ub;
      case (alu_op_t'(op))
        OP_ADD:   x = ua + ub;
        OP_SUB:   x = ua - ub;
        OP_AND:   x = ua & ub;
        OP_OR:    x = ua | ub;
        OP_XOR:   x = ua ^ ub;
        OP_MIN:   x = (sa < sb) ? sa : sb;
        OP_MAX:   x = (sa > sb) ? sa : sb;
        OP_MINU:  x = (ua < ub) ? ua : ub;
        OP_MAXU:  x = (ua > ub) ? ua : ub;
        OP_SLT:   x = (sa < sb) ? 1 : 0;
        OP_SLTU:  x = (ua < ub) ? 1 : 0;
        OP_SEQ:   x = (ua == ub) ? 1 : 0;
        OP_MUL:   x = sa * sb;
        OP_MULH:  x = (sa * sb) >>> w;
        OP_MULHU: begin
          pu = longint'(ua) * longint'(ub);
          x  = longint'(pu >> w);
        end
        default:  x = 0;
      endcase
      r = r | 32'((x & mask) << (i*w));
    end
    return r;
  endfunction

  // Model of one accepted beat: pushes any result that must appear.
  function automatic void model_accept(input logic [3:0] op, input logic [1:0] sew,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic red, input logic first, input logic last);
    logic [3:0] eop;
    if (!red) begin
      exp_q.push_back(ref_op(op, sew, a, b));
    end else begin
      eop = (alu_op_t'(op) inside {OP_ADD, OP_AND, OP_OR, OP_XOR, OP_MIN, OP_MAX,
                                   OP_MINU, OP_MAXU}) ? op : 4'(OP_ADD);
      m_acc = first ? ref_op(eop, sew, a, b) : ref_op(eop, sew, m_acc, b);
      if (last) exp_q.push_back(m_acc);
    end
  endfunction

  task automatic drive_beat(input logic [3:0] op, input logic [1:0] sew,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic red, input logic first, input logic last);
    vld_i = 1'b1; op_i = op; sew_i = sew; op1_i = a; op2_i = b;
    red_i = red; red_first_i = first; red_last_i = last;
  endtask

  task automatic idle();
    vld_i = 1'b0; red_i = 1'b0; red_first_i = 1'b0; red_last_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    m_acc = '0;
    exp_q.delete();
  endtask

  // Observe vld_o for ncyc negedges with rdy_i high; returns hit count,
  // index of the first hit and its result. Ends realigned to posedge+1.
  task automatic watch(input int ncyc, output int hits, output int first_k,
                       output logic [31:0] first_res);
    hits = 0; first_k = -1; first_res = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (vld_o) begin
        if (hits == 0) begin
          first_k = k;
          first_res = result_o;
        end
        hits++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rdy_i = 1'b1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%b want=0", vld_o); end
    n_vec++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL reset_rdy got=%b want=1", rdy_o); end
    n_vec++; if (result_o !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h want=0", result_o); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL post_reset_rdy got=%b want=1", rdy_o); end
    n_vec++; if (vld_o !== 1'b0) begin n_err++; $display("FAIL post_reset_vld got=%b want=0", vld_o); end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sew;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } dvec_t;

  task automatic test_directed();
    dvec_t tbl[$];
    int hits, k;
    logic [31:0] res;
    tbl.push_back('{4'(OP_ADD),   2'b00, 32'h7F01FF80, 32'h01010101, 32'h80020081});
    tbl.push_back('{4'(OP_MULH),  2'b01, 32'h80000002, 32'h80000003, 32'h40000000});
    tbl.push_back('{4'(OP_MULHU), 2'b01, 32'h80000002, 32'h80000003, 32'h40000000});
    tbl.push_back('{4'(OP_SLT),   2'b10, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
    tbl.push_back('{4'(OP_SLTU),  2'b10, 32'hFFFFFFFF, 32'h00000000, 32'h00000000});
    tbl.push_back('{4'(OP_SUB),   2'b00, 32'h00010203, 32'h01010101, 32'hFF000102});
    tbl.push_back('{4'(OP_SEQ),   2'b01, 32'h12345678, 32'h12340000, 32'h00010000});
    tbl.push_back('{4'(OP_MIN),   2'b00, 32'h80017F02, 32'h7F028001, 32'h80018001});
    tbl.push_back('{4'(OP_MINU),  2'b00, 32'h80017F02, 32'h7F028001, 32'h7F017F01});
    tbl.push_back('{4'(OP_ADD),   2'b11, 32'h00FF00FF, 32'h00010001, 32'h01000100});
    tbl.push_back('{4'(OP_RSVD),  2'b10, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
    tbl.push_back('{4'(OP_MUL),   2'b00, 32'hFF030210, 32'hFF050310, 32'h010F0600});
    foreach (tbl[i]) begin
      drive_beat(tbl[i].op, tbl[i].sew, tbl[i].a, tbl[i].b, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      idle();
      watch(10, hits, k, res);
      n_vec++;
      if (hits != 1 || k != LATENCY-1) begin
        n_err++;
        $display("FAIL directed_latency[%0d] got hits=%0d latency=%0d want hits=1 latency=%0d",
                 i, hits, k+1, LATENCY);
      end
      n_vec++;
      if (res !== tbl[i].e) begin
        n_err++;
        $display("FAIL directed_result[%0d] got=%h want=%h", i, res, tbl[i].e);
      end
    end
  endtask

  task automatic test_reduction();
    int hits, k;
    logic [31:0] res;
    rdy_i = 1'b1;
    drive_beat(4'(OP_MAX), 2'b10, 32'd5, 32'd3, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_beat(4'(OP_MAX), 2'b10, 32'd77, 32'd9, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_beat(4'(OP_MAX), 2'b10, 32'd77, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    idle();
    watch(10, hits, k, res);
    n_vec++;
    if (hits != 1 || k != LATENCY-1) begin
      n_err++;
      $display("FAIL red_max_vld got hits=%0d at=%0d want hits=1 at=%0d", hits, k, LATENCY-1);
    end
    n_vec++;
    if (res !== 32'd9) begin n_err++; $display("FAIL red_max_result got=%h want=9", res); end

    // Single-beat reduction with a non-reducible opcode folds as ADD.
    drive_beat(4'(OP_SLT), 2'b00, 32'h01020304, 32'h10101010, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    idle();
    watch(10, hits, k, res);
    n_vec++;
    if (hits != 1 || res !== 32'h11121314) begin
      n_err++;
      $display("FAIL red_fallback_add got hits=%0d res=%h want hits=1 res=11121314", hits, res);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    rdy_i = 1'b1;
    fork
      begin : drv
        logic [31:0] a, b;
        int w;
        for (int i = 0; i < 6; i++) begin
          a = $urandom; b = $urandom;
          drive_beat(4'(OP_ADD), 2'b00, a, b, 1'b0, 1'b0, 1'b0);
          @(negedge clk);
          w = 0;
          while (!rdy_o && w < 50) begin
            @(negedge clk);
            w++;
          end
          n_vec++;
          if (!rdy_o) begin n_err++; $display("FAIL b2b_accept_timeout got rdy_o=0 want 1"); end
          else exp_q.push_back(ref_op(4'(OP_ADD), 2'b00, a, b));
          @(posedge clk); #1;
        end
        idle();
      end
      begin : rcv
        int got, w;
        logic [31:0] held;
        got = 0; w = 0; held = '0;
        @(negedge clk);
        while (!vld_o && w < 30) begin
          @(negedge clk);
          w++;
        end
        n_vec++;
        if (!vld_o || exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_first_out got vld_o=%b want 1", vld_o);
        end else begin
          if (result_o !== exp_q[0]) begin
            n_err++; $display("FAIL b2b_data[0] got=%h want=%h", result_o, exp_q[0]);
          end
          void'(exp_q.pop_front());
          got++;
        end
        @(posedge clk); #1;
        rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          n_vec++;
          if (rdy_o !== 1'b0 || vld_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_stall[%0d] got rdy_o=%b vld_o=%b want rdy_o=0 vld_o=1", k, rdy_o, vld_o);
          end
          n_vec++;
          if (k == 0) begin
            held = result_o;
            if (exp_q.size() == 0 || result_o !== exp_q[0]) begin
              n_err++; $display("FAIL b2b_stall_data got=%h want head of queue", result_o);
            end
          end else if (result_o !== held) begin
            n_err++; $display("FAIL b2b_hold[%0d] got=%h want=%h", k, result_o, held);
          end
        end
        @(posedge clk); #1;
        rdy_i = 1'b1;
        w = 0;
        while (got < 6 && w < 40) begin
          @(negedge clk);
          w++;
          if (vld_o) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL b2b_extra got=%h want no beat", result_o);
            end else begin
              if (result_o !== exp_q[0]) begin
                n_err++; $display("FAIL b2b_data[%0d] got=%h want=%h", got, result_o, exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
            got++;
          end
        end
        n_vec++;
        if (got != 6) begin n_err++; $display("FAIL b2b_count got=%0d want=6", got); end
        w = 0;
        repeat (6) begin
          @(negedge clk);
          if (vld_o) w++;
        end
        n_vec++;
        if (w != 0) begin n_err++; $display("FAIL b2b_duplicate got=%0d extra beats want=0", w); end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int hits, k, w;
    logic [31:0] res;
    rdy_i = 1'b1;
    drive_beat(4'(OP_ADD), 2'b10, 32'd10, 32'd20, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_beat(4'(OP_ADD), 2'b10, 32'd0, 32'd5, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    idle();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    watch(10, hits, k, res);
    n_vec++;
    if (hits != 0) begin n_err++; $display("FAIL rst_mid_red got vld count=%0d want=0", hits); end

    // Reset while the output is stalled.
    rdy_i = 1'b0;
    drive_beat(4'(OP_XOR), 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    w = 0;
    @(negedge clk);
    while (!vld_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (rdy_o !== 1'b0 || vld_o !== 1'b1) begin
      n_err++; $display("FAIL rst_stall_setup got rdy_o=%b vld_o=%b want 0/1", rdy_o, vld_o);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (vld_o !== 1'b0 || result_o !== 32'h0 || rdy_o !== 1'b1) begin
      n_err++; $display("FAIL rst_stall_clear got vld_o=%b result=%h rdy_o=%b want 0/0/1", vld_o, result_o, rdy_o);
    end
    @(posedge clk); #1;
    rdy_i = 1'b1;
    watch(6, hits, k, res);
    n_vec++;
    if (hits != 0) begin n_err++; $display("FAIL rst_stall_flush got vld count=%0d want=0", hits); end

    // Fresh reduction after the reset.
    drive_beat(4'(OP_ADD), 2'b00, 32'h01020304, 32'h01010101, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_beat(4'(OP_ADD), 2'b00, 32'hFFFFFFFF, 32'h10101010, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    idle();
    watch(10, hits, k, res);
    n_vec++;
    if (hits != 1 || res !== 32'h12131415) begin
      n_err++; $display("FAIL rst_fresh_red got hits=%0d res=%h want hits=1 res=12131415", hits, res);
    end

    // Reset must clear the accumulator: a headless beat combines with zero.
    do_reset();
    drive_beat(4'(OP_ADD), 2'b10, 32'hDEADBEEF, 32'd7, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    idle();
    watch(10, hits, k, res);
    n_vec++;
    if (hits != 1 || res !== 32'd7) begin
      n_err++; $display("FAIL acc_cleared got hits=%0d res=%h want hits=1 res=7", hits, res);
    end
  endtask

  task automatic test_random();
    logic done;
    logic [31:0] edges[4];
    edges[0] = 32'h00000000; edges[1] = 32'hFFFFFFFF;
    edges[2] = 32'h80808080; edges[3] = 32'h7F7F7F7F;
    do_reset();
    done = 1'b0;
    fork
      begin : drv
        int acc_n, cyc;
        logic [3:0] op;
        logic [1:0] sew;
        logic [31:0] a, b;
        logic red, first, last;
        acc_n = 0; cyc = 0;
        while (acc_n < 300 && cyc < 3000) begin
          op  = 4'($urandom_range(0, 15));
          sew = 2'($urandom_range(0, 3));
          a   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
          b   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
          red   = ($urandom_range(0, 2) == 0);
          first = red && ($urandom_range(0, 3) == 0);
          last  = red && ($urandom_range(0, 2) == 0);
          drive_beat(op, sew, a, b, red, first, last);
          vld_i = ($urandom_range(0, 3) != 0);
          rdy_i = ($urandom_range(0, 9) < 7);
          @(negedge clk);
          if (vld_i && rdy_o) begin
            model_accept(op, sew, a, b, red, first, last);
            acc_n++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        idle();
        rdy_i = 1'b1;
        done = 1'b1;
      end
      begin : rcv
        int cyc;
        logic prev_stall;
        logic [31:0] prev_res;
        cyc = 0; prev_stall = 1'b0; prev_res = '0;
        while (!(done && exp_q.size() == 0) && cyc < 6000) begin
          @(negedge clk);
          cyc++;
          if (prev_stall) begin
            n_vec++;
            if (vld_o !== 1'b1 || result_o !== prev_res) begin
              n_err++; $display("FAIL rnd_hold got vld_o=%b result=%h want 1/%h", vld_o, result_o, prev_res);
            end
          end
          if (vld_o && rdy_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL rnd_unexpected got=%h want no beat", result_o);
            end else begin
              if (result_o !== exp_q[0]) begin
                n_err++; $display("FAIL rnd_data got=%h want=%h", result_o, exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
          end
          prev_stall = vld_o && !rdy_i;
          prev_res   = result_o;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
          n_err++; $display("FAIL rnd_drain got %0d pending want 0", exp_q.size());
        end
      end
    join
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reduction();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
